sysid_boot_checker: RTL and testbench
=====================================

# sysid_boot_checker

Avalon-MM read master that sits directly upstream of the system ID slave and consumes its 32-bit readdata. After reset, or on request, it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and holds the captured words plus a pass/fail verdict for the boot controller and status LEDs. It turns a passive ID register into an active hardware/software build-consistency check.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0
- EXPECTED_TIMESTAMP, 32'h639D_07E1 (1671235553), expected word at address 1
- READ_LATENCY, 0, fixed slave read latency in cycles (0..3); data is sampled this many cycles after the accepted read
- TIMEOUT_CYCLES, 255, maximum waitrequest stall per read (used only with the timeout feature)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; requests a new check
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for a slave without stall
- avm_readdata  in  32  slave read data
- id_value  out  32  captured ID word
- timestamp_value  out  32  captured timestamp word
- busy  out  1  check in progress
- done  out  1  check finished; held until next check starts
- match  out  1  both words equal expected; valid while done=1
- timeout  out  1  a read stalled past TIMEOUT_CYCLES; valid while done=1

## Operation
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- Internal start_pending flag: set by reset, set by start pulse while not busy; consumed on IDLE->RD_ID.
- IDLE: avm_read=0; start_pending=1 -> RD_ID, clear done/match/timeout.
- RD_ID: avm_read=1, avm_address=0; held stable while avm_waitrequest=1. On accept (waitrequest=0): READ_LATENCY=0 -> capture avm_readdata into id_value, go RD_TS; else -> LAT_ID.
- LAT_ID: avm_read=0; down-counter of READ_LATENCY cycles; capture on final count -> RD_TS.
- RD_TS / LAT_TS: identical with address 1, capture into timestamp_value, then FINISH.
- FINISH: one cycle; match <= (id_value==EXPECTED_ID) && (timestamp_value==EXPECTED_TIMESTAMP) && !timeout; done<=1 -> IDLE.
- start while busy: ignored, not queued. start in IDLE with done=1: new check, done cleared on entry to RD_ID.
- Captured values retained after done until overwritten by next check.

## Timing
- Reset values: avm_read=0, avm_address=0, id_value=0, timestamp_value=0, busy=0, done=0, match=0, timeout=0; start_pending=1.
- First clock edge after reset release: IDLE->RD_ID (auto-start).
- No stall: latency start-accept to done=1 is 2*(1+READ_LATENCY)+2 edges (READ_LATENCY=0: 4 edges).
- Each waitrequest cycle adds one cycle.
- busy=1 in RD_ID through FINISH inclusive.
- avm_address changes only while avm_read=0 or on the accepting edge.
- Reset mid-check: all outputs to reset values immediately; auto-start follows.

## Configuration
- SYSID_CHECK_TIMEOUT_EN defined: 8-bit-or-wider stall counter per read, cleared on entering RD_ID/RD_TS; reaching TIMEOUT_CYCLES with waitrequest still 1 drops avm_read, sets timeout=1, skips to FINISH (match=0, unread value stays 0).
- Not defined: no counter; FSM waits indefinitely on waitrequest; timeout tied 0.

## Structure
- Package sysid_check_pkg: FSM state enum, address constants ADDR_ID=0 and ADDR_TS=1, default expected-value constants.
- One sub-module: sysid_read_port — issues one Avalon read (address, waitrequest hold, latency counter, optional timeout) and returns data plus a done/timeout pulse; top FSM sequences two instances of its use.

## Test plan
- Reset release, slave returns 0 at addr 0 and 1671235553 at addr 1, READ_LATENCY=0, no stall -> done=1 at edge 4, match=1, id_value=0, timestamp_value=32'h639D07E1.
- Slave returns 32'h639D07E0 at addr 1 -> done=1, match=0, timestamp_value=32'h639D07E0.
- READ_LATENCY=2, waitrequest high 3 cycles on first read -> avm_address/avm_read stable during stall, done at edge 2*3+2+3=11, match=1.
- With SYSID_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck 1 -> avm_read drops after 8 stall cycles, timeout=1, match=0, done=1.
- start pulse during RD_TS -> ignored, exactly two reads total; start after done -> done clears, new two-read sequence, done again.
- reset_n low during LAT_ID -> all outputs 0 asynchronously; after release full check re-runs and passes.

Source files
------------

// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_check_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      FINISH
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam logic [31:0] DEF_EXPECTED_ID        = 32'h0000_0000;
   localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'h639D_07E1;

   // Stall counter is never narrower than 8 bits.
   function automatic int stall_cnt_width(input int limit);
      return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
   endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only bus between the boot checker (master) and the system ID slave.
interface sysid_boot_checker_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );
endinterface

// File: rtl/sysid_boot_checker_read_port.sv
// One Avalon read: strobe held through waitrequest, data strobed READ_LATENCY cycles after accept.
// SYSID_CHECK_TIMEOUT_EN adds a per-read stall counter that aborts after TIMEOUT_CYCLES stalls.
module sysid_read_port
   import sysid_check_pkg::*;
#(
   parameter int READ_LATENCY = 0
`ifdef SYSID_CHECK_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 rd,
   input  logic                 lat,
   input  logic                 addr,
   sysid_boot_checker_if.master avm,
   output logic                 accept,
   output logic                 cap,
   output logic                 tmo,
   output logic [31:0]          data
);

   localparam logic [1:0] LAT_LOAD = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   logic [1:0] lat_cnt;

   assign avm.avm_read    = rd;
   assign avm.avm_address = addr;
   assign accept          = rd && !avm.avm_waitrequest;
   assign data            = avm.avm_readdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt <= 2'd0;
      end else if (accept) begin
         lat_cnt <= LAT_LOAD;
      end else if (lat && (lat_cnt != 2'd0)) begin
         lat_cnt <= lat_cnt - 2'd1;
      end
   end

   // Zero latency: data is on the bus in the accepting cycle itself.
   assign cap = (READ_LATENCY == 0) ? accept : (lat && (lat_cnt == 2'd0));

`ifdef SYSID_CHECK_TIMEOUT_EN
   localparam int SW = stall_cnt_width(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

   logic [SW-1:0] stall_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (!rd || accept) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign tmo = rd && avm.avm_waitrequest && (stall_cnt == STALL_LAST);
`else
   assign tmo = 1'b0;
`endif

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads sysid ID/timestamp after reset or on start, compares to build constants; 2*(1+READ_LATENCY)+2 cycles unstalled.
// Waits out waitrequest; SYSID_CHECK_TIMEOUT_EN bounds each stall to TIMEOUT_CYCLES and flags timeout.
module sysid_boot_checker
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
   parameter int          READ_LATENCY       = 0,
   parameter int          TIMEOUT_CYCLES     = 255
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   sysid_boot_checker_if.master avm,
   output logic [31:0]          id_value,
   output logic [31:0]          timestamp_value,
   output logic                 busy,
   output logic                 done,
   output logic                 match,
   output logic                 timeout
);

   state_t      state, state_nxt;
   logic        start_pending;
   logic        rd, lat, addr;
   logic        accept, cap, tmo;
   logic [31:0] rdata;
   logic        launch;

   sysid_read_port #(
      .READ_LATENCY   (READ_LATENCY)
`ifdef SYSID_CHECK_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
   ) u_read_port (
      .clock   (clock),
      .reset_n (reset_n),
      .rd      (rd),
      .lat     (lat),
      .addr    (addr),
      .avm     (avm),
      .accept  (accept),
      .cap     (cap),
      .tmo     (tmo),
      .data    (rdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd        = 1'b0;
      lat       = 1'b0;
      addr      = ADDR_ID;
      case (state)
         IDLE: begin
            if (start_pending) state_nxt = RD_ID;
         end
         RD_ID: begin
            rd = 1'b1;
            if (tmo)         state_nxt = FINISH;
            else if (accept) state_nxt = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
         end
         LAT_ID: begin
            lat = 1'b1;
            if (cap) state_nxt = RD_TS;
         end
         RD_TS: begin
            rd   = 1'b1;
            addr = ADDR_TS;
            if (tmo)         state_nxt = FINISH;
            else if (accept) state_nxt = (READ_LATENCY == 0) ? FINISH : LAT_TS;
         end
         LAT_TS: begin
            lat  = 1'b1;
            addr = ADDR_TS;
            if (cap) state_nxt = FINISH;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy   = (state != IDLE);
   assign launch = (state == IDLE) && start_pending;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_pending   <= 1'b1;
         id_value        <= 32'h0;
         timestamp_value <= 32'h0;
         done            <= 1'b0;
         match           <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         // A request arriving while a check runs is dropped, not queued.
         if (launch)              start_pending <= 1'b0;
         else if (start && !busy) start_pending <= 1'b1;

         if (launch) begin
            done    <= 1'b0;
            match   <= 1'b0;
            timeout <= 1'b0;
         end

         if (cap && ((state == RD_ID) || (state == LAT_ID))) id_value        <= rdata;
         if (cap && ((state == RD_TS) || (state == LAT_TS))) timestamp_value <= rdata;
`ifdef SYSID_CHECK_TIMEOUT_EN
         if (tmo) timeout <= 1'b1;
`endif
         if (state == FINISH) begin
            match <= (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP) && !timeout;
            done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: zero-latency checker (a) and READ_LATENCY=2 checker (b) against simple sysid slave models.
module tb_sysid_boot_checker;

   logic clk = 1'b0;
   logic rst_n;
   logic start_a, start_b;
   logic wr_b;
   logic [31:0] id_a, ts_a, id_b, ts_b;

   logic [31:0] idv_a, tsv_a, idv_b, tsv_b;
   logic        busy_a, done_a, match_a, tmo_a;
   logic        busy_b, done_b, match_b, tmo_b;

   int n_cmp = 0;
   int n_bad = 0;
   int reads_a = 0;
   int reads_b = 0;
   int base;

   always #5 clk = ~clk;

   sysid_boot_checker_if bus_a ();
   sysid_boot_checker_if bus_b ();

   // Slave a: zero latency, no stall, garbage when not read.
   assign bus_a.avm_waitrequest = 1'b0;
   assign bus_a.avm_readdata    = bus_a.avm_read ? (bus_a.avm_address ? ts_a : id_a) : 32'hDEAD_BEEF;

   // Slave b: data valid exactly two cycles after the accepting edge.
   logic [1:0] pv = 2'b00;
   logic [1:0] pa = 2'b00;
   always @(posedge clk) begin
      pv <= {pv[0], bus_b.avm_read && !bus_b.avm_waitrequest};
      pa <= {pa[0], bus_b.avm_address};
   end
   assign bus_b.avm_waitrequest = wr_b;
   assign bus_b.avm_readdata    = pv[1] ? (pa[1] ? ts_b : id_b) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (bus_a.avm_read && !bus_a.avm_waitrequest) reads_a <= reads_a + 1;
      if (bus_b.avm_read && !bus_b.avm_waitrequest) reads_b <= reads_b + 1;
   end

   sysid_boot_checker #(
      .EXPECTED_ID        (32'h0000_0000),
      .EXPECTED_TIMESTAMP (32'h639D_07E1),
      .READ_LATENCY       (0),
      .TIMEOUT_CYCLES     (255)
   ) dut_a (
      .clock           (clk),
      .reset_n         (rst_n),
      .start           (start_a),
      .avm             (bus_a),
      .id_value        (idv_a),
      .timestamp_value (tsv_a),
      .busy            (busy_a),
      .done            (done_a),
      .match           (match_a),
      .timeout         (tmo_a)
   );

   sysid_boot_checker #(
      .EXPECTED_ID        (32'h0000_0000),
      .EXPECTED_TIMESTAMP (32'h639D_07E1),
      .READ_LATENCY       (2),
      .TIMEOUT_CYCLES     (8)
   ) dut_b (
      .clock           (clk),
      .reset_n         (rst_n),
      .start           (start_b),
      .avm             (bus_b),
      .id_value        (idv_b),
      .timestamp_value (tsv_b),
      .busy            (busy_b),
      .done            (done_b),
      .match           (match_b),
      .timeout         (tmo_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; wr_b = 1'b0;
      id_a = 32'h0; ts_a = 32'h639D_07E1; id_b = 32'h0; ts_b = 32'h639D_07E1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_busy", busy_a, 0);   chk("rst_a_done", done_a, 0);
      chk("rst_a_match", match_a, 0); chk("rst_a_tmo", tmo_a, 0);
      chk("rst_a_id", idv_a, 0);      chk("rst_a_ts", tsv_a, 0);
      chk("rst_a_read", bus_a.avm_read, 0); chk("rst_a_addr", bus_a.avm_address, 0);
      chk("rst_b_read", bus_b.avm_read, 0); chk("rst_b_busy", busy_b, 0);

      // Auto-start after release; b stalls three cycles on its first read.
      wr_b = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      step(); // edge 1
      chk("e1_a_busy", busy_a, 1); chk("e1_a_read", bus_a.avm_read, 1);
      chk("e1_a_addr", bus_a.avm_address, 0); chk("e1_b_read", bus_b.avm_read, 1);
      step(); // edge 2
      chk("e2_a_addr", bus_a.avm_address, 1); chk("e2_a_read", bus_a.avm_read, 1);
      chk("e2_b_read", bus_b.avm_read, 1); chk("e2_b_addr", bus_b.avm_address, 0);
      step(); // edge 3
      chk("e3_a_done", done_a, 0); chk("e3_b_addr", bus_b.avm_address, 0);
      step(); // edge 4
      chk("e4_a_done", done_a, 1);  chk("e4_a_match", match_a, 1);
      chk("e4_a_id", idv_a, 32'h0); chk("e4_a_ts", tsv_a, 32'h639D_07E1);
      chk("e4_a_busy", busy_a, 0);  chk("e4_a_tmo", tmo_a, 0);
      chk("e4_b_read", bus_b.avm_read, 1); chk("e4_b_addr", bus_b.avm_address, 0);
      wr_b = 1'b0;
      step(); // edge 5: b accepted, now in latency wait
      chk("e5_b_read", bus_b.avm_read, 0); chk("e5_b_busy", busy_b, 1);
      chk("e5_a_reads", reads_a, 2);
      step(); step(); // edge 7
      chk("e7_b_read", bus_b.avm_read, 1); chk("e7_b_addr", bus_b.avm_address, 1);
      step(); step(); step(); // edge 10
      chk("e10_b_done", done_b, 0);
      step(); // edge 11
      chk("e11_b_done", done_b, 1); chk("e11_b_match", match_b, 1);
      chk("e11_b_id", idv_b, 32'h0); chk("e11_b_ts", tsv_b, 32'h639D_07E1);
      chk("e11_b_tmo", tmo_b, 0); chk("e11_b_reads", reads_b, 2);

      // Timestamp off by one: check reruns on start and reports mismatch.
      ts_a = 32'h639D_07E0;
      base = reads_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("mm_done_held", done_a, 1);
      step();
      chk("mm_done_clr", done_a, 0); chk("mm_busy", busy_a, 1);
      step(); step(); step();
      chk("mm_done", done_a, 1); chk("mm_match", match_a, 0);
      chk("mm_ts", tsv_a, 32'h639D_07E0); chk("mm_reads", reads_a - base, 2);

      // start while reading the timestamp must be ignored.
      ts_a = 32'h639D_07E1;
      base = reads_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step(); step();
      chk("ig_addr", bus_a.avm_address, 1); chk("ig_read", bus_a.avm_read, 1);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step();
      chk("ig_done", done_a, 1); chk("ig_match", match_a, 1);
      repeat (5) step();
      chk("ig_done_hold", done_a, 1); chk("ig_busy", busy_a, 0);
      chk("ig_reads", reads_a - base, 2);

      // Reset asserted while b is in its first latency wait.
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      step(); step();
      chk("lr_b_read", bus_b.avm_read, 0); chk("lr_b_busy", busy_b, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_b_busy", busy_b, 0); chk("ar_b_read", bus_b.avm_read, 0);
      chk("ar_b_ts", tsv_b, 0);    chk("ar_b_done", done_b, 0);
      chk("ar_a_done", done_a, 0); chk("ar_a_match", match_a, 0);
      chk("ar_a_ts", tsv_a, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (7) step();
      chk("rr_b_done7", done_b, 0);
      step();
      chk("rr_b_done8", done_b, 1); chk("rr_b_match", match_b, 1);
      chk("rr_b_ts", tsv_b, 32'h639D_07E1);
      chk("rr_a_done", done_a, 1); chk("rr_a_match", match_a, 1);

`ifdef SYSID_CHECK_TIMEOUT_EN
      // waitrequest stuck high: read drops after 8 stall cycles.
      start_b = 1'b1;
      wr_b    = 1'b1;
      step();
      start_b = 1'b0;
      repeat (8) step();
      chk("to_read_hold", bus_b.avm_read, 1);
      step();
      chk("to_read_drop", bus_b.avm_read, 0); chk("to_flag", tmo_b, 1);
      step();
      chk("to_done", done_b, 1); chk("to_match", match_b, 0); chk("to_tmo", tmo_b, 1);
      wr_b = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
